// File: rtl/lc3_alu_sequencer.sv
// rtl/lc3_alu_sequencer.sv - multi-cycle execute controller for LC-3 ADD/AND/NOT
module lc3_alu_sequencer #(
  parameter int         DATA_W    = 16,
  parameter logic [2:0] NZP_RESET = 3'b010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [2:0]        rf_raddr1,
  output logic [2:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rf_we,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        nzp,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;

  state_t            state, state_nxt;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] op_a, op_b;
  logic              is_add, is_and, is_not, is_legal;
  logic [DATA_W-1:0] imm_ext;

  assign is_add   = (instr_q[15:12] == 4'b0001);
  assign is_and   = (instr_q[15:12] == 4'b0101);
  assign is_not   = (instr_q[15:12] == 4'b1001) && (instr_q[5:0] == 6'h3F);
  assign is_legal = is_add || is_and || is_not;
  assign imm_ext  = {{(DATA_W-5){instr_q[4]}}, instr_q[4:0]};

  // Read addresses come straight from the captured word; they only matter during READ.
  assign rf_raddr1 = instr_q[8:6];
  assign rf_raddr2 = instr_q[2:0];

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    alu_op      = OP_PASS;
    alu_a       = '0;
    alu_b       = '0;
    rf_we       = 1'b0;
    rf_waddr    = 3'd0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ: begin
        if (is_legal) begin
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
          done      = 1'b1;
          illegal   = 1'b1;
        end
      end
      EXEC: begin
        alu_a     = op_a;
        // NOT also has bit 5 set, so it must not pick up the immediate.
        alu_b     = (instr_q[5] && !is_not) ? imm_ext : op_b;
        alu_op    = is_add ? OP_ADD : (is_and ? OP_AND : OP_NOT);
        state_nxt = WB;
      end
      WB: begin
        rf_we     = 1'b1;
        rf_waddr  = instr_q[11:9];
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      instr_q  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      rf_wdata <= '0;
      nzp      <= NZP_RESET;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) instr_q <= instr;
      // Operands are frozen here so a WB to SR1/SR2 cannot disturb them.
      if (state == READ) begin
        op_a <= rf_rdata1;
        op_b <= rf_rdata2;
      end
      if (state == EXEC) rf_wdata <= alu_result;
      if (state == WB) begin
        if (rf_wdata[DATA_W-1])  nzp <= 3'b100;
        else if (rf_wdata == '0) nzp <= 3'b010;
        else                     nzp <= 3'b001;
      end
    end
  end

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// tb/tb_lc3_alu_sequencer.sv - self-checking bench for lc3_alu_sequencer
module tb_lc3_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rf_raddr1, rf_raddr2;
  logic [15:0] rf_rdata1, rf_rdata2;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [2:0]  nzp;
  logic        done;
  logic        illegal;

  lc3_alu_sequencer #(.DATA_W(16), .NZP_RESET(3'b010)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .nzp(nzp), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Register file and ALU surrounding the sequencer.
  logic [15:0] regs [8];
  logic [15:0] init_regs [8];
  logic        load;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++) regs[i] <= init_regs[i];
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a & alu_b;
      3'b010:  alu_result = ~alu_a;
      default: alu_result = alu_a;
    endcase
  end

  typedef struct {
    logic [15:0] ins;
    logic [2:0]  ra;
    logic [15:0] va;
    logic [2:0]  rb;
    logic [15:0] vb;
    logic        ill;
    logic [15:0] res;
    logic [2:0]  flags;
    logic [2:0]  op;
  } vec_t;

  vec_t        tbl [9];
  logic [15:0] model_regs [8];
  logic [2:0]  model_nzp;
  int          n_cmp = 0;
  int          n_bad = 0;

  int          done_k, done_n, ill_n, we_n, we_k;
  logic [2:0]  got_waddr, got_op, got_nzp;
  logic [15:0] got_wdata;
  logic [3:0]  ready_mask;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic load_regs();
    for (int i = 0; i < 8; i++) model_regs[i] = init_regs[i];
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(negedge clk);
  endtask

  // Starts on a negedge with the sequencer idle; ends on the 4th negedge after accept.
  task automatic issue(input logic [15:0] ins);
    chk("ready_before_accept", {31'd0, instr_ready}, 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    instr = 16'($urandom);
    done_k = -1; done_n = 0; ill_n = 0; we_n = 0; we_k = -1;
    got_waddr = '0; got_wdata = '0; got_op = '0; ready_mask = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (illegal) ill_n++;
      if (rf_we) begin
        we_n++;
        we_k      = k;
        got_waddr = rf_waddr;
        got_wdata = rf_wdata;
      end
      if (k == 2) got_op = alu_op;
      ready_mask[k-1] = instr_ready;
    end
    got_nzp = nzp;
  endtask

  function automatic logic [2:0] flags_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0)     return 3'b010;
    return 3'b001;
  endfunction

  task automatic check_result(input string tag, input logic [15:0] ins, input logic ill,
                              input logic [15:0] res, input logic [2:0] flags, input logic [2:0] op);
    chk({tag, ".done_n"}, done_n, 1);
    if (!ill) begin
      chk({tag, ".done_k"}, done_k, 3);
      chk({tag, ".illegal"}, ill_n, 0);
      chk({tag, ".we_n"}, we_n, 1);
      chk({tag, ".we_k"}, we_k, 3);
      chk({tag, ".waddr"}, got_waddr, ins[11:9]);
      chk({tag, ".wdata"}, got_wdata, res);
      chk({tag, ".alu_op"}, got_op, op);
      chk({tag, ".nzp"}, got_nzp, flags);
      chk({tag, ".ready"}, ready_mask, 4'b1000);
      model_regs[ins[11:9]] = res;
      model_nzp = flags;
    end else begin
      chk({tag, ".done_k"}, done_k, 1);
      chk({tag, ".illegal"}, ill_n, 1);
      chk({tag, ".we_n"}, we_n, 0);
      chk({tag, ".nzp_kept"}, got_nzp, model_nzp);
      chk({tag, ".ready"}, ready_mask, 4'b1110);
    end
  endtask

  task automatic run_vec(input int idx);
    for (int i = 0; i < 8; i++) init_regs[i] = 16'($urandom);
    init_regs[tbl[idx].ra] = tbl[idx].va;
    init_regs[tbl[idx].rb] = tbl[idx].vb;
    load_regs();
    issue(tbl[idx].ins);
    check_result($sformatf("vec%0d", idx), tbl[idx].ins, tbl[idx].ill,
                 tbl[idx].res, tbl[idx].flags, tbl[idx].op);
  endtask

  initial begin
    logic [15:0] ins, a, b, res;
    logic        legal;
    logic [2:0]  op;
    int          d1, d2, dn, we_cnt;
    logic [15:0] wd1, wd2;
    logic [7:0]  rmask;

    tbl[0] = '{16'h1283, 3'd2, 16'd5,     3'd3, 16'd7,     1'b0, 16'd12,   3'b001, 3'b000};
    tbl[1] = '{16'h103F, 3'd0, 16'd0,     3'd7, 16'h1234,  1'b0, 16'hFFFF, 3'b100, 3'b000};
    tbl[2] = '{16'h9DC0, 3'd7, 16'h00FF,  3'd0, 16'h0001,  1'b1, 16'd0,    3'b000, 3'b011};
    tbl[3] = '{16'h103F, 3'd0, 16'd1,     3'd7, 16'h4321,  1'b0, 16'd0,    3'b010, 3'b000};
    tbl[4] = '{16'h0000, 3'd0, 16'h8000,  3'd0, 16'h8000,  1'b1, 16'd0,    3'b000, 3'b011};
    tbl[5] = '{16'h5960, 3'd5, 16'hABCD,  3'd0, 16'h1111,  1'b0, 16'd0,    3'b010, 3'b001};
    tbl[6] = '{16'h9DFF, 3'd7, 16'h00FF,  3'd7, 16'h00FF,  1'b0, 16'hFF00, 3'b100, 3'b010};
    tbl[7] = '{16'h5A42, 3'd1, 16'hF0F0,  3'd2, 16'h3C3C,  1'b0, 16'h3030, 3'b001, 3'b001};
    tbl[8] = '{16'h16C4, 3'd3, 16'h7FFF,  3'd4, 16'h0001,  1'b0, 16'h8000, 3'b100, 3'b000};

    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0; load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.instr_ready", instr_ready, 1);
    chk("rst.alu_op", alu_op, 3'b011);
    chk("rst.alu_a", alu_a, 0);
    chk("rst.alu_b", alu_b, 0);
    chk("rst.rf_raddr1", rf_raddr1, 0);
    chk("rst.rf_raddr2", rf_raddr2, 0);
    chk("rst.rf_we", rf_we, 0);
    chk("rst.rf_waddr", rf_waddr, 0);
    chk("rst.rf_wdata", rf_wdata, 0);
    chk("rst.nzp", nzp, 3'b010);
    chk("rst.done", done, 0);
    chk("rst.illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_nzp = 3'b010;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Randomized instructions against the instruction-level model.
    for (int i = 0; i < 8; i++) init_regs[i] = 16'($urandom);
    load_regs();
    for (int it = 0; it < 40; it++) begin
      ins = 16'($urandom);
      case ($urandom_range(0, 3))
        0: ins[15:12] = 4'b0001;
        1: ins[15:12] = 4'b0101;
        2: begin
          ins[15:12] = 4'b1001;
          if ($urandom_range(0, 3) != 0) ins[5:0] = 6'h3F;
        end
        default: ;
      endcase
      a = model_regs[ins[8:6]];
      b = ins[5] ? 16'($signed(ins[4:0])) : model_regs[ins[2:0]];
      legal = 1'b1; op = 3'b011; res = 16'd0;
      if (ins[15:12] == 4'b0001)                          begin res = a + b; op = 3'b000; end
      else if (ins[15:12] == 4'b0101)                     begin res = a & b; op = 3'b001; end
      else if (ins[15:12] == 4'b1001 && ins[5:0] == 6'h3F) begin res = ~a;   op = 3'b010; end
      else legal = 1'b0;
      issue(ins);
      check_result($sformatf("rnd%0d", it), ins, !legal, res, flags_of(res), op);
    end

    // Back-to-back: valid held high across two instructions; second reads R1 written by first.
    init_regs[2] = 16'd5; init_regs[3] = 16'd7;
    load_regs();
    d1 = -1; d2 = -1; dn = 0; wd1 = '0; wd2 = '0; rmask = '0;
    instr = 16'h1283; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = 16'h1861;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (dn == 1) begin d1 = k; wd1 = rf_wdata; end
        if (dn == 2) begin d2 = k; wd2 = rf_wdata; instr_valid = 1'b0; end
      end
      rmask[k-1] = instr_ready;
    end
    instr_valid = 1'b0;
    chk("b2b.done1_k", d1, 3);
    chk("b2b.done2_k", d2, 7);
    chk("b2b.wdata1", wd1, 16'd12);
    chk("b2b.wdata2", wd2, 16'd13);
    chk("b2b.ready", rmask, 8'b1000_1000);
    chk("b2b.nzp", nzp, 3'b001);
    model_nzp = 3'b001;

    // Reset pulsed during EXEC of an ADD.
    instr = 16'h1283; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rstx.in_exec_op", alu_op, 3'b000);
    rst_n = 1'b0;
    #1;
    chk("rstx.instr_ready", instr_ready, 1);
    chk("rstx.alu_op", alu_op, 3'b011);
    chk("rstx.alu_a", alu_a, 0);
    chk("rstx.rf_we", rf_we, 0);
    chk("rstx.done", done, 0);
    chk("rstx.nzp", nzp, 3'b010);
    chk("rstx.rf_wdata", rf_wdata, 0);
    chk("rstx.rf_raddr1", rf_raddr1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_nzp = 3'b010;
    we_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rf_we || done) we_cnt++;
    end
    chk("rstx.no_retire", we_cnt, 0);
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_alu_sequencer.md
Name: lc3_alu_sequencer

Overview:
- Multi-cycle execute controller for the LC-3 operate instructions ADD, AND and NOT.
- Accepts one 16-bit instruction over a valid/ready handshake, decodes it and drives register-file read addresses.
- Presents operands and the operation code to the combinational ALU, writes the result back and updates the NZP condition codes.
- Sits between the fetch/decode front end and the register file + ALU pair.

Parameters:
- DATA_W, 16, datapath width; must match ALU operand width.
- NZP_RESET, 3'b010, condition-code value after reset (Z set).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction available on instr.
- instr  input  16  LC-3 instruction word.
- instr_ready  output  1  sequencer can accept an instruction.
- rf_raddr1  output  3  register-file read address 1 (SR1).
- rf_raddr2  output  3  register-file read address 2 (SR2).
- rf_rdata1  input  DATA_W  combinational read data for rf_raddr1.
- rf_rdata2  input  DATA_W  combinational read data for rf_raddr2.
- alu_a  output  DATA_W  ALU operand A.
- alu_b  output  DATA_W  ALU operand B.
- alu_op  output  3  ALU operation: ADD=000, AND=001, NOT=010, PASS=011.
- alu_result  input  DATA_W  combinational ALU result.
- rf_we  output  1  register-file write enable, one-cycle pulse.
- rf_waddr  output  3  write address (DR).
- rf_wdata  output  DATA_W  write data.
- nzp  output  3  condition codes {N,Z,P}.
- done  output  1  one-cycle pulse when an instruction retires (legal or illegal).
- illegal  output  1  one-cycle pulse, coincident with done, for an unsupported encoding.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state=IDLE, instr_ready=1.
  - alu_op=011, alu_a=alu_b=0.
  - rf_raddr1=rf_raddr2=0, rf_we=0, rf_waddr=0, rf_wdata=0.
  - nzp=NZP_RESET, done=0, illegal=0.
  - Captured instruction register cleared.
- States IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready: latch instr and go to READ.
  - instr_ready is high only in IDLE; throughput is 1 instruction per 4 cycles.
- READ:
  - rf_raddr1=instr[8:6], rf_raddr2=instr[2:0]; sample rf_rdata1/2 into operand registers.
  - Decode:
    - opcode 0001=ADD.
    - opcode 0101=AND.
    - opcode 1001 with instr[5:0]=111111 = NOT.
  - Any other encoding: go to IDLE, pulse done=1 and illegal=1 in that transition cycle. No rf_we; nzp unchanged.
- EXEC:
  - alu_a = SR1 data.
  - alu_b = sign-extended instr[4:0] when instr[5]=1 (ADD/AND), otherwise SR2 data. For NOT, alu_b = SR2 data (don't care to the ALU).
  - alu_op = 000 / 001 / 010 per decode; register alu_result into rf_wdata at the end of the cycle.
  - Outside EXEC, alu_op=011.
- WB:
  - rf_we=1, rf_waddr=instr[11:9], done=1 for exactly one cycle.
  - nzp updates at the end of WB: N=rf_wdata[15]; Z when rf_wdata==0; P otherwise. Exactly one bit is set.
  - Next state IDLE; instr_ready rises the following cycle.
- Latency from the accept edge: rf_we/done are asserted 3 cycles later; nzp is visible 4 cycles later.
- Arithmetic wraps modulo 2^DATA_W; no carry or overflow output.
- DR equal to SR1/SR2: operands are captured in READ, so the write in WB never affects the in-flight operands.
- instr_valid while busy is ignored; the instr value is not sampled until the next IDLE handshake.
- Reset mid-operation:
  - Abandons the instruction immediately.
  - rf_we and done are not asserted for it.
  - nzp returns to NZP_RESET.

Test Plan:
- Reset then ADD R1,R2,R3 (instr=16'h1283), R2=5, R3=7 -> after the accept edge, READ, EXEC (alu_op=000), then WB cycle with rf_we=1, rf_waddr=1, rf_wdata=12, done=1; nzp=001 afterwards.
- ADD R0,R0,#-1 (16'h103F) with R0=0 -> rf_wdata=16'hFFFF, nzp=100; with R0=1 -> rf_wdata=0, nzp=010.
- AND R4,R5,#0 (16'h5960), R5=16'hABCD -> rf_wdata=0, nzp=010; NOT R6,R7 (16'h9DFF), R7=16'h00FF -> alu_op=010, rf_wdata=16'hFF00, nzp=100.
- Illegal: 16'h9DC0 (NOT with bad low bits) and 16'h0000 -> done=illegal=1 pulse, rf_we never asserted, nzp unchanged, instr_ready back to 1 within 2 cycles of the accept edge.
- Back-to-back: instr_valid held high with two instructions -> the second is accepted only when instr_ready returns; instr_ready is low in READ/EXEC/WB; retire spacing is exactly 4 cycles.
- rst_n pulsed low during EXEC of an ADD -> outputs return to reset values asynchronously, no rf_we pulse, nzp=010, and the next instruction executes normally.
